// File: rtl/logic_arb_pkg.sv
// Shared definitions for the arbitrated bitwise logic unit: opcode encoding and FSM states.
package logic_arb_pkg;

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND  = 3'd0;
   localparam logic [OP_W-1:0] OP_OR   = 3'd1;
   localparam logic [OP_W-1:0] OP_NAND = 3'd2;
   localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
   localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
   localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
   localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

   typedef enum logic [0:0] {StIdle, StFull} state_e;

endpackage

// File: rtl/logic_unit_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from pointer+1, pointer moves to winner on grant.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_idx,
   output logic               gnt_any
);

   logic [ID_W-1:0] ptr_q;
   logic            found;

   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      gnt     = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         int unsigned idx;
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req[idx]) begin
            found   = 1'b1;
            gnt_idx = ID_W'(idx);
         end
      end
      gnt_any = en & found;
      if (gnt_any) gnt[gnt_idx] = 1'b1;
   end

   // Reset to the last index so requester 0 wins the first arbitration.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= ID_W'(NUM_REQ - 1);
      end else if (gnt_any) begin
         ptr_q <= gnt_idx;
      end
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one registered bitwise logic unit among NUM_REQ requesters with round-robin arbitration.
// Optional LOGIC_ARB_STATS_EN adds a saturating accepted-request counter on port stat_ops.
module logic_unit_arbiter
   import logic_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 8,
   localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [OP_W*NUM_REQ-1:0]  req_op,
   input  logic [WIDTH*NUM_REQ-1:0] req_a,
   input  logic [WIDTH*NUM_REQ-1:0] req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WIDTH-1:0]         rsp_data,
   output logic [ID_W-1:0]          rsp_id,
   output logic                     rsp_err
`ifdef LOGIC_ARB_STATS_EN
   ,
   output logic [15:0]              stat_ops
`endif
);

   state_e            state_q;
   logic              grant_en;
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]   gnt_idx;
   logic              gnt_any;
   logic [OP_W-1:0]   sel_op;
   logic [WIDTH-1:0]  sel_a;
   logic [WIDTH-1:0]  sel_b;
   logic [WIDTH-1:0]  alu_res;
   logic              alu_err;

   // A held result blocks new grants until the consumer takes it.
   assign grant_en  = !rst && (state_q == StIdle || rsp_ready);
   assign req_ready = gnt;

   rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_rr (
      .clk    (clk),
      .rst    (rst),
      .req    (req_valid),
      .en     (grant_en),
      .gnt    (gnt),
      .gnt_idx(gnt_idx),
      .gnt_any(gnt_any)
   );

   always_comb begin
      sel_op  = req_op[int'(gnt_idx)*OP_W +: OP_W];
      sel_a   = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
      sel_b   = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
      alu_err = 1'b0;
      case (sel_op)
         OP_AND:  alu_res = sel_a & sel_b;
         OP_OR:   alu_res = sel_a | sel_b;
         OP_NAND: alu_res = ~(sel_a & sel_b);
         OP_NOR:  alu_res = ~(sel_a | sel_b);
         OP_XOR:  alu_res = sel_a ^ sel_b;
         OP_XNOR: alu_res = ~(sel_a ^ sel_b);
         OP_NOT:  alu_res = ~sel_a;
         default: begin
            alu_res = '0;
            alu_err = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
         rsp_err   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (gnt_any) begin
                  state_q   <= StFull;
                  rsp_valid <= 1'b1;
                  rsp_data  <= alu_res;
                  rsp_id    <= gnt_idx;
                  rsp_err   <= alu_err;
               end
            end
            StFull: begin
               if (rsp_ready) begin
                  if (gnt_any) begin
                     rsp_data <= alu_res;
                     rsp_id   <= gnt_idx;
                     rsp_err  <= alu_err;
                  end else begin
                     state_q   <= StIdle;
                     rsp_valid <= 1'b0;
                  end
               end
            end
            default: begin
               state_q   <= StIdle;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef LOGIC_ARB_STATS_EN
   logic [15:0] stat_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_q <= '0;
      end else if (gnt_any && stat_q != 16'hFFFF) begin
         stat_q <= stat_q + 16'd1;
      end
   end

   assign stat_ops = stat_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus randomized traffic vs a model.
module tb_logic_unit_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [3*N-1:0] req_op;
   logic [W*N-1:0] req_a;
   logic [W*N-1:0] req_b;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [W-1:0]   rsp_data;
   logic [IW-1:0]  rsp_id;
   logic           rsp_err;
`ifdef LOGIC_ARB_STATS_EN
   logic [15:0]    stat_ops;
`endif

   always #5 clk = ~clk;

   logic_unit_arbiter #(
      .NUM_REQ(N),
      .WIDTH  (W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_op   (req_op),
      .req_a    (req_a),
      .req_b    (req_b),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data (rsp_data),
      .rsp_id   (rsp_id),
      .rsp_err  (rsp_err)
`ifdef LOGIC_ARB_STATS_EN
      ,
      .stat_ops (stat_ops)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: result register contents, occupancy, last winner and op count.
   bit         m_full;
   logic [W-1:0] m_data;
   int         m_id;
   bit         m_err;
   int         m_ptr;
   int         m_stats;
   int         last_w;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Each opcode as a per-bit truth table indexed by {a,b}.
   function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      logic [3:0]   tt;
      logic [W-1:0] r;
      case (op)
         0:       tt = 4'b1000;
         1:       tt = 4'b1110;
         2:       tt = 4'b0111;
         3:       tt = 4'b0001;
         4:       tt = 4'b0110;
         5:       tt = 4'b1001;
         6:       tt = 4'b0011;
         default: tt = 4'b0000;
      endcase
      for (int i = 0; i < W; i++) r[i] = tt[{a[i], b[i]}];
      return r;
   endfunction

   function automatic int winner();
      if (rst) return -1;
      if (m_full && !rsp_ready) return -1;
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   task automatic step(input string tag);
      int           w;
      logic [N-1:0] eg;
      int           op;
      #1;
      w  = winner();
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      chk({tag, ":req_ready"}, 32'(req_ready), 32'(eg));
      @(posedge clk);
      if (rst) begin
         m_full = 0; m_data = '0; m_id = 0; m_err = 0; m_ptr = N - 1; m_stats = 0;
      end else if (w >= 0) begin
         op      = int'(req_op[3*w +: 3]);
         m_full  = 1;
         m_data  = ref_op(op, req_a[W*w +: W], req_b[W*w +: W]);
         m_id    = w;
         m_err   = (op == 7);
         m_ptr   = w;
         if (m_stats < 65535) m_stats++;
      end else if (m_full && rsp_ready) begin
         m_full = 0;
      end
      last_w = w;
      #1;
      chk({tag, ":rsp_valid"}, 32'(rsp_valid), 32'(m_full));
      chk({tag, ":rsp_data"}, 32'(rsp_data), 32'(m_data));
      chk({tag, ":rsp_id"}, 32'(rsp_id), 32'(m_id));
      chk({tag, ":rsp_err"}, 32'(rsp_err), 32'(m_err));
`ifdef LOGIC_ARB_STATS_EN
      chk({tag, ":stat_ops"}, 32'(stat_ops), 32'(m_stats));
`endif
   endtask

   task automatic set_req(input int i, input bit v, input int op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
      req_valid[i]    = v;
      req_op[3*i +: 3] = 3'(op);
      req_a[W*i +: W] = a;
      req_b[W*i +: W] = b;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step("reset");
      rst = 1'b0;
   endtask

   initial begin
      logic [W-1:0] exp2 [8];
      exp2 = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h5A, 8'h00};
      rst = 1'b1; rsp_ready = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
      last_w = -1;
      step("reset0");
      step("reset1");
      rst = 1'b0;
      chk("reset_valid", 32'(rsp_valid), 32'd0);
      chk("reset_data", 32'(rsp_data), 32'd0);

      // Single AND from requester 0
      rsp_ready = 1'b1;
      set_req(0, 1, 0, 8'hF0, 8'h3C);
      step("single");
      chk("single_data", 32'(rsp_data), 32'h30);
      chk("single_id", 32'(rsp_id), 32'd0);
      set_req(0, 0, 0, 8'h00, 8'h00);
      step("drain");

      // Every opcode on requester 1
      for (int k = 0; k < 8; k++) begin
         set_req(1, 1, k, 8'hA5, 8'h0F);
         step("opcode");
         chk("opcode_data", 32'(rsp_data), 32'(exp2[k]));
         chk("opcode_err", 32'(rsp_err), 32'(k == 7));
      end
      set_req(1, 0, 0, 8'h00, 8'h00);
      step("drain");

      // Fairness after reset: 0,1,2,3,0,...
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 1, 4, W'(i * 17), 8'h5A);
      for (int c = 0; c < 8; c++) begin
         step("fair");
         chk("fair_id", 32'(rsp_id), 32'(c % N));
      end

      // Backpressure with a held result
      rsp_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step("bp");
         chk("bp_ready", 32'(req_ready), 32'd0);
         chk("bp_id", 32'(rsp_id), 32'd3);
      end
      rsp_ready = 1'b1;
      step("bp_release");
      chk("bp_release_id", 32'(rsp_id), 32'd0);

      // Reset while FULL
      rst = 1'b1;
      step("midrst");
      chk("midrst_valid", 32'(rsp_valid), 32'd0);
      rst = 1'b0;
      step("post_rst");
      chk("post_rst_id", 32'(rsp_id), 32'd0);

      // Randomized traffic; payload only changes once a request is idle or accepted
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || last_w == i || rst)
               set_req(i, ($urandom_range(0, 9) < 6), int'($urandom_range(0, 7)),
                       W'($urandom), W'($urandom));
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 59) == 0);
         step("rand");
      end
      rst = 1'b0;

`ifdef LOGIC_ARB_STATS_EN
      do_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1, 0, 8'hFF, 8'h0F);
      for (int c = 0; c < 70000; c++) step("stats");
      chk("stats_sat", 32'(stat_ops), 32'hFFFF);
      do_reset();
      chk("stats_clr", 32'(stat_ops), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
